// File: rtl/frac_div_ctrl.sv
// Fractional clock-divider controller: alternates INT / INT+1 periods
// from a first-order accumulator, reconfigured only on period boundaries.
module frac_div_ctrl #(
  parameter int CNT_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_num,
  input  logic [FRAC_W-1:0] cfg_den,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              period_start,
  output logic [CNT_W:0]    cur_len
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic              ld_vld, pd_vld;
  logic [CNT_W-1:0]  ld_int, pd_int, nx_int;
  logic [FRAC_W-1:0] ld_num, pd_num, nx_num;
  logic [FRAC_W-1:0] ld_den, pd_den, nx_den;
  logic [FRAC_W-1:0] acc, acc_nx, acc_base;
  logic [CNT_W:0]    cnt, cnt_inc, len_nx;
  logic [FRAC_W:0]   sum, diff;
  logic              legal, xfer, take;
  logic              chg, bnd, start;

  assign cfg_ready = (state == S_IDLE) || !pd_vld;
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_int >= CNT_W'(2))
                  && (cfg_den != '0)
                  && (cfg_num < cfg_den);
  assign take      = xfer && legal;
  assign cnt_inc   = cnt + 1'b1;
  assign bnd       = (state == S_RUN) && (cnt_inc == cur_len);
  assign start     = (state == S_IDLE) && en
                  && (ld_vld || take);

  // Effective next config: same-cycle transfer, then pending, then loaded
  always_comb begin
    nx_int = ld_int;
    nx_num = ld_num;
    nx_den = ld_den;
    if (take) begin
      nx_int = cfg_int;
      nx_num = cfg_num;
      nx_den = cfg_den;
    end else if (pd_vld) begin
      nx_int = pd_int;
      nx_num = pd_num;
      nx_den = pd_den;
    end
    chg      = {nx_int, nx_num, nx_den}
            != {ld_int, ld_num, ld_den};
    acc_base = chg ? {FRAC_W{1'b0}} : acc;
    sum      = {1'b0, acc_base} + {1'b0, nx_num};
    diff     = sum - {1'b0, nx_den};
    if (sum >= {1'b0, nx_den}) begin
      len_nx = {1'b0, nx_int} + 1'b1;
      acc_nx = diff[FRAC_W-1:0];
    end else begin
      len_nx = {1'b0, nx_int};
      acc_nx = sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= S_IDLE;
      ld_vld       <= 1'b0;
      pd_vld       <= 1'b0;
      ld_int       <= '0;
      ld_num       <= '0;
      ld_den       <= '0;
      pd_int       <= '0;
      pd_num       <= '0;
      pd_den       <= '0;
      acc          <= '0;
      cnt          <= '0;
      cur_len      <= '0;
      clk_out      <= 1'b0;
      period_start <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err      <= xfer && !legal;
      period_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (take) begin
            ld_int <= cfg_int;
            ld_num <= cfg_num;
            ld_den <= cfg_den;
            ld_vld <= 1'b1;
          end
          if (start) begin
            state        <= S_RUN;
            cnt          <= '0;
            cur_len      <= len_nx;
            acc          <= acc_nx;
            period_start <= 1'b1;
            clk_out      <= (len_nx >> 1) != '0;
          end else if (chg) begin
            acc <= '0;
          end
        end
        S_RUN: begin
          if (bnd) begin
            ld_int <= nx_int;
            ld_num <= nx_num;
            ld_den <= nx_den;
            pd_vld <= 1'b0;
            cnt    <= '0;
            if (en) begin
              cur_len      <= len_nx;
              acc          <= acc_nx;
              period_start <= 1'b1;
              clk_out      <= (len_nx >> 1) != '0;
            end else begin
              state   <= S_IDLE;
              cur_len <= '0;
              clk_out <= 1'b0;
              if (chg) acc <= '0;
            end
          end else begin
            cnt     <= cnt_inc;
            clk_out <= cnt_inc < (cur_len >> 1);
            if (take) begin
              pd_int <= cfg_int;
              pd_num <= cfg_num;
              pd_den <= cfg_den;
              pd_vld <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frac_div_ctrl.sv
// Directed bench for frac_div_ctrl: period sequences, handshake,
// illegal configs, boundary reconfiguration, en drop and reset.
module tb_frac_div_ctrl;
  localparam int CNT_W  = 8;
  localparam int FRAC_W = 8;

  logic              clk_in = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_int = '0;
  logic [FRAC_W-1:0] cfg_num = '0;
  logic [FRAC_W-1:0] cfg_den = '0;
  logic              cfg_err;
  logic              clk_out;
  logic              period_start;
  logic [CNT_W:0]    cur_len;

  always #5 clk_in = ~clk_in;

  frac_div_ctrl #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
    .clk_in(clk_in), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_num(cfg_num), .cfg_den(cfg_den),
    .cfg_err(cfg_err), .clk_out(clk_out),
    .period_start(period_start), .cur_len(cur_len)
  );

  int checks = 0;
  int errors = 0;
  int lens[$];
  int his[$];
  int clks[$];
  int hi_acc = 0;
  int clk_acc = 0;
  bit in_per = 1'b0;
  int exp87[10] = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};

  // Period monitor: length, high cycles and total cycles per period
  always @(negedge clk_in) begin
    if (rst) begin
      in_per = 1'b0;
    end else begin
      if (in_per && (period_start || cur_len == 0)) begin
        his.push_back(hi_acc);
        clks.push_back(clk_acc);
        in_per = 1'b0;
      end
      if (period_start) begin
        lens.push_back(int'(cur_len));
        hi_acc = 0;
        clk_acc = 0;
        in_per = 1'b1;
      end
      if (in_per) begin
        hi_acc += int'(clk_out);
        clk_acc++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    cfg_valid = 1'b0;
    cyc();
    cyc();
    lens.delete();
    his.delete();
    clks.delete();
    rst = 1'b0;
  endtask

  task automatic send(input int i, input int n, input int d,
                      output bit rdy, output bit err);
    cfg_int = CNT_W'(i);
    cfg_num = FRAC_W'(n);
    cfg_den = FRAC_W'(d);
    cfg_valid = 1'b1;
    rdy = cfg_ready;
    cyc();
    cfg_valid = 1'b0;
    err = cfg_err;
  endtask

  task automatic wait_his(input int n, output bit to);
    int k;
    k = 0;
    while (his.size() < n && k < 3000) begin
      cyc();
      k++;
    end
    to = (his.size() < n);
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    cyc();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rst_clk_out got %0b exp 0", clk_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_ps got %0b exp 0", period_start); end
    checks++; if (cur_len !== '0) begin errors++; $display("FAIL rst_len got %0d exp 0", cur_len); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", cfg_ready); end
    rst = 1'b0;
  endtask

  task automatic test_frac_87();
    bit r, e, to;
    int tot;
    do_reset();
    en = 1'b1;
    send(8, 7, 10, r, e);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL f87_ready got %0b exp 1", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL f87_err got %0b exp 0", e); end
    checks++; if (period_start !== 1'b1 || cur_len !== 9'd8) begin errors++; $display("FAIL f87_first got ps=%0b len=%0d exp ps=1 len=8", period_start, cur_len); end
    wait_his(10, to);
    checks++; if (to) begin errors++; $display("FAIL f87_timeout got %0d periods exp 10", his.size()); end
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (lens[i] !== exp87[i]) begin errors++; $display("FAIL f87_len[%0d] got %0d exp %0d", i, lens[i], exp87[i]); end
      checks++; if (his[i] !== 4) begin errors++; $display("FAIL f87_high[%0d] got %0d exp 4", i, his[i]); end
      tot += clks[i];
    end
    checks++; if (tot !== 87) begin errors++; $display("FAIL f87_total got %0d exp 87", tot); end
  endtask

  task automatic test_int3();
    bit r, e, to;
    do_reset();
    en = 1'b1;
    send(3, 0, 1, r, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL i3_err got %0b exp 0", e); end
    wait_his(4, to);
    checks++; if (to) begin errors++; $display("FAIL i3_timeout got %0d periods exp 4", his.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (lens[i] !== 3 || clks[i] !== 3) begin errors++; $display("FAIL i3_len[%0d] got %0d/%0d exp 3/3", i, lens[i], clks[i]); end
      checks++; if (his[i] !== 1) begin errors++; $display("FAIL i3_high[%0d] got %0d exp 1", i, his[i]); end
    end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL i3_err_late got %0b exp 0", cfg_err); end
  endtask

  task automatic test_illegal();
    bit r, e, to;
    int tot;
    do_reset();
    en = 1'b1;
    send(8, 7, 10, r, e);
    cyc();
    send(1, 0, 1, r, e);
    checks++; if (r !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL ill_int got rdy=%0b err=%0b exp 1/1", r, e); end
    cyc();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL ill_pulse got %0b exp 0", cfg_err); end
    send(5, 5, 5, r, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_numden got %0b exp 1", e); end
    send(4, 0, 0, r, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_den0 got %0b exp 1", e); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %0b exp 1", cfg_ready); end
    wait_his(10, to);
    checks++; if (to) begin errors++; $display("FAIL ill_timeout got %0d periods exp 10", his.size()); end
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (lens[i] !== exp87[i]) begin errors++; $display("FAIL ill_len[%0d] got %0d exp %0d", i, lens[i], exp87[i]); end
      tot += clks[i];
    end
    checks++; if (tot !== 87) begin errors++; $display("FAIL ill_total got %0d exp 87", tot); end
  endtask

  task automatic test_new_cfg();
    bit r, e, to;
    int n;
    int exp_l[5] = '{8, 4, 5, 4, 5};
    do_reset();
    en = 1'b1;
    send(8, 7, 10, r, e);
    cyc();
    cyc();
    send(4, 1, 2, r, e);
    checks++; if (r !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL new_xfer got rdy=%0b err=%0b exp 1/0", r, e); end
    n = 0;
    while (!cfg_ready && n < 20) begin
      n++;
      cyc();
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL new_ready_low got %0d cycles exp 5", n); end
    checks++; if (period_start !== 1'b1 || cur_len !== 9'd4) begin errors++; $display("FAIL new_apply got ps=%0b len=%0d exp 1/4", period_start, cur_len); end
    wait_his(5, to);
    checks++; if (to) begin errors++; $display("FAIL new_timeout got %0d periods exp 5", his.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (lens[i] !== exp_l[i]) begin errors++; $display("FAIL new_len[%0d] got %0d exp %0d", i, lens[i], exp_l[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit r, e, to;
    int exp_l[5] = '{3, 5, 6, 6, 5};
    do_reset();
    en = 1'b1;
    send(3, 0, 1, r, e);
    cyc();
    cyc();
    send(5, 2, 3, r, e);
    checks++; if (r !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL bnd_xfer got rdy=%0b err=%0b exp 1/0", r, e); end
    checks++; if (period_start !== 1'b1 || cur_len !== 9'd5) begin errors++; $display("FAIL bnd_apply got ps=%0b len=%0d exp 1/5", period_start, cur_len); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready got %0b exp 1", cfg_ready); end
    wait_his(5, to);
    checks++; if (to) begin errors++; $display("FAIL bnd_timeout got %0d periods exp 5", his.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (lens[i] !== exp_l[i]) begin errors++; $display("FAIL bnd_len[%0d] got %0d exp %0d", i, lens[i], exp_l[i]); end
    end
  endtask

  task automatic test_en_drop();
    bit r, e;
    int n;
    do_reset();
    en = 1'b1;
    send(8, 7, 10, r, e);
    repeat (8) cyc();
    checks++; if (period_start !== 1'b1 || cur_len !== 9'd9) begin errors++; $display("FAIL drop_p1 got ps=%0b len=%0d exp 1/9", period_start, cur_len); end
    cyc();
    cyc();
    en = 1'b0;
    n = 0;
    while (cur_len != 0 && n < 50) begin
      cyc();
      n++;
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL drop_cycles got %0d exp 7", n); end
    checks++; if (clk_out !== 1'b0 || period_start !== 1'b0) begin errors++; $display("FAIL drop_idle got clk=%0b ps=%0b exp 0/0", clk_out, period_start); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %0b exp 1", cfg_ready); end
  endtask

  task automatic test_rst_mid();
    en = 1'b1;
    repeat (3) cyc();
    checks++; if (cur_len === '0 || clk_out !== 1'b1) begin errors++; $display("FAIL rmid_run got len=%0d clk=%0b exp nonzero/1", cur_len, clk_out); end
    rst = 1'b1;
    cyc();
    checks++; if (clk_out !== 1'b0 || cur_len !== '0) begin errors++; $display("FAIL rmid_out got clk=%0b len=%0d exp 0/0", clk_out, cur_len); end
    checks++; if (period_start !== 1'b0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin errors++; $display("FAIL rmid_ctl got ps=%0b rdy=%0b err=%0b exp 0/1/0", period_start, cfg_ready, cfg_err); end
    lens.delete();
    rst = 1'b0;
    repeat (20) cyc();
    checks++; if (cur_len !== '0 || clk_out !== 1'b0) begin errors++; $display("FAIL rmid_idle got len=%0d clk=%0b exp 0/0", cur_len, clk_out); end
    checks++; if (lens.size() !== 0) begin errors++; $display("FAIL rmid_starts got %0d exp 0", lens.size()); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frac_87();
    test_int3();
    test_illegal();
    test_new_cfg();
    test_back_to_back();
    test_en_drop();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
